// File: rtl/pipe_core_fwd.sv
// Five-stage in-order pipeline (IF/ID/EX/MEM/WB) with full operand forwarding,
// load-use interlock, EX-resolved branches and a sticky halt.
module pipe_core_fwd #(
    parameter int DATA_W  = 32,
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 10
) (
    input  logic               clk1,
    input  logic               rst,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic [4:0]         dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               halted
);
    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010,
                           OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101,
                           OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010,
                           OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
                           OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;

    function automatic logic signed [DATA_W-1:0] alu(input logic [5:0] op,
            input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
            input logic signed [DATA_W-1:0] imm);
        case (op)
            OP_ADD:                return a + b;
            OP_SUB:                return a - b;
            OP_AND:                return a & b;
            OP_OR:                 return a | b;
            OP_SLT:                return (a < b) ? DATA_W'(1) : '0;
            OP_MUL:                return a * b;
            OP_LW, OP_SW, OP_ADDI: return a + imm;
            OP_SUBI:               return a - imm;
            OP_SLTI:               return (a < imm) ? DATA_W'(1) : '0;
            default:               return '0;
        endcase
    endfunction

    logic [DATA_W-1:0] rf [32];
    logic [IADDR_W-1:0] pc;

    logic               vld_p1;
    logic [31:0]        ir_p1;
    logic [IADDR_W-1:0] npc_p1;

    logic                     vld_p2, wen_p2;
    logic [5:0]               op_p2;
    logic [4:0]               rs_p2, rt_p2, dst_p2;
    logic signed [DATA_W-1:0] a_p2, b_p2, imm_p2;
    logic [IADDR_W-1:0]       npc_p2;

    logic                     vld_p3, wen_p3;
    logic [5:0]               op_p3;
    logic [4:0]               dst_p3;
    logic signed [DATA_W-1:0] alu_p3, sd_p3;

    logic              vld_p4, wen_p4;
    logic [5:0]        op_p4;
    logic [4:0]        dst_p4;
    logic [DATA_W-1:0] alu_p4, mdr_p4;

    logic [5:0]               op_d;
    logic [4:0]               rs_d, rt_d, dst_d;
    logic                     use_rs_d, use_rt_d, wen_d, rr_d;
    logic signed [DATA_W-1:0] imm_d, rs_val_d, rt_val_d;
    logic signed [DATA_W-1:0] fa, fb, alu_x;
    logic [IADDR_W-1:0]       target;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_we, stall, taken, hlt_block;

    assign imem_addr = pc;
    assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf[dbg_raddr];
    assign wb_data   = (op_p4 == OP_LW) ? mdr_p4 : alu_p4;
    assign wb_we     = vld_p4 && wen_p4 && !halted;

    // ID: decode, register read with same-cycle WB bypass
    always_comb begin
        op_d = ir_p1[31:26];
        case (op_d)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_LW, OP_SW, OP_ADDI,
            OP_SUBI, OP_SLTI, OP_BNEQZ, OP_BEQZ: ;
            default: op_d = OP_HLT;
        endcase
        rs_d     = ir_p1[25:21];
        rt_d     = ir_p1[20:16];
        imm_d    = DATA_W'($signed(ir_p1[15:0]));
        rr_d     = op_d inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
        use_rs_d = (op_d != OP_HLT);
        use_rt_d = rr_d || (op_d == OP_SW);
        dst_d    = rr_d ? ir_p1[15:11] : rt_d;
        wen_d    = (rr_d || op_d inside {OP_LW, OP_ADDI, OP_SUBI, OP_SLTI}) && (dst_d != 5'd0);
        rs_val_d = (wb_we && dst_p4 == rs_d) ? wb_data : rf[rs_d];
        rt_val_d = (wb_we && dst_p4 == rt_d) ? wb_data : rf[rt_d];
        stall    = vld_p1 && vld_p2 && (op_p2 == OP_LW) && wen_p2 &&
                   ((use_rs_d && rs_d == dst_p2) || (use_rt_d && rt_d == dst_p2));
    end

    // EX: forwarding EX/MEM over MEM/WB over register-file value
    always_comb begin
        fa = a_p2;
        if (vld_p3 && wen_p3 && dst_p3 == rs_p2)      fa = alu_p3;
        else if (wb_we && dst_p4 == rs_p2)            fa = wb_data;
        fb = b_p2;
        if (vld_p3 && wen_p3 && dst_p3 == rt_p2)      fb = alu_p3;
        else if (wb_we && dst_p4 == rt_p2)            fb = wb_data;
        alu_x     = alu(op_p2, fa, fb, imm_p2);
        target    = npc_p2 + imm_p2[IADDR_W-1:0];
        taken     = vld_p2 && (((op_p2 == OP_BEQZ) && (fa == '0)) ||
                               ((op_p2 == OP_BNEQZ) && (fa != '0)));
        hlt_block = (vld_p2 && op_p2 == OP_HLT) || (vld_p3 && op_p3 == OP_HLT) ||
                    (vld_p4 && op_p4 == OP_HLT);
    end

    // MEM: stores only for a valid SW, never while reset or halted
    assign dmem_addr  = alu_p3[DADDR_W-1:0];
    assign dmem_wdata = sd_p3;
    assign dmem_we    = vld_p3 && (op_p3 == OP_SW) && !halted && !rst;

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc     <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (taken)                      pc <= target;
            else if (!hlt_block && !stall)  pc <= pc + IADDR_W'(1);
            if (taken || hlt_block)         vld_p1 <= 1'b0;
            else if (!stall)                vld_p1 <= 1'b1;
            vld_p2 <= vld_p1 && !taken && !hlt_block && !stall;
            vld_p3 <= vld_p2;
            vld_p4 <= vld_p3;
            if (vld_p4 && op_p4 == OP_HLT)  halted <= 1'b1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[dst_p4] <= wb_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (!halted) begin
            if (!stall) begin
                ir_p1  <= imem_rdata;
                npc_p1 <= pc + IADDR_W'(1);
            end
            op_p2  <= op_d;
            rs_p2  <= rs_d;
            rt_p2  <= rt_d;
            dst_p2 <= dst_d;
            wen_p2 <= wen_d;
            a_p2   <= rs_val_d;
            b_p2   <= rt_val_d;
            imm_p2 <= imm_d;
            npc_p2 <= npc_p1;
            op_p3  <= op_p2;
            dst_p3 <= dst_p2;
            wen_p3 <= wen_p2;
            alu_p3 <= alu_x;
            sd_p3  <= fb;
            op_p4  <= op_p3;
            dst_p4 <= dst_p3;
            wen_p4 <= wen_p3;
            alu_p4 <= alu_p3;
            mdr_p4 <= dmem_rdata;
        end
    end
endmodule

// File: tb/tb_pipe_core_fwd.sv
// Directed bench: runs short programs on a 32-bit and a 16-bit core in lockstep
// and checks registers, stores, cycle counts and halt/reset behaviour.
module tb_pipe_core_fwd;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011,
                           SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001,
                           ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100,
                           BNEQZ = 6'b001101, BEQZ = 6'b001110;
    localparam logic [31:0] HLT = 32'hFC00_0000;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst;
    logic [4:0]  dbg_raddr;
    logic [31:0] imem [1024];
    logic [9:0]  ia_a, da_a, ia_b, da_b;
    logic [31:0] dwd_a, drd_a, dbg_a;
    logic [15:0] dwd_b, drd_b, dbg_b;
    logic        we_a, we_b, hlt_a, hlt_b;
    logic [31:0] dm_a [1024];
    logic [15:0] dm_b [1024];
    logic        pl_we;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;
    int          st_a = 0, st_b = 0;
    logic [9:0]  sa_a, sa_b;
    logic [31:0] sd_a;
    logic [15:0] sd_b;
    int          vectors = 0, miscompares = 0;

    assign drd_a = dm_a[da_a];
    assign drd_b = dm_b[da_b];

    always @(posedge clk1) begin
        if (pl_we) begin
            dm_a[pl_addr] <= pl_data;
            dm_b[pl_addr] <= pl_data[15:0];
        end
        if (we_a) begin
            dm_a[da_a] <= dwd_a; st_a <= st_a + 1; sa_a <= da_a; sd_a <= dwd_a;
        end
        if (we_b) begin
            dm_b[da_b] <= dwd_b; st_b <= st_b + 1; sa_b <= da_b; sd_b <= dwd_b;
        end
    end

    pipe_core_fwd #(.DATA_W(32), .IADDR_W(10), .DADDR_W(10)) u32 (
        .clk1(clk1), .rst(rst), .imem_addr(ia_a), .imem_rdata(imem[ia_a]),
        .dmem_addr(da_a), .dmem_wdata(dwd_a), .dmem_we(we_a), .dmem_rdata(drd_a),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_a), .halted(hlt_a));

    pipe_core_fwd #(.DATA_W(16), .IADDR_W(10), .DADDR_W(10)) u16 (
        .clk1(clk1), .rst(rst), .imem_addr(ia_b), .imem_rdata(imem[ia_b]),
        .dmem_addr(da_b), .dmem_wdata(dwd_b), .dmem_we(we_b), .dmem_rdata(drd_b),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_b), .halted(hlt_b));

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    endtask

    task automatic chk_reg(input string tag, input int r, input logic [31:0] e);
        dbg_raddr = 5'(r);
        #1;
        check({tag, "/w32"}, 64'(dbg_a), 64'(e));
        check({tag, "/w16"}, 64'(dbg_b), 64'(e[15:0]));
    endtask

    // Reset, release, then count edges until both cores report halted.
    task automatic run(input string tag, input int exp_cyc);
        int cyc, ca, cb;
        cyc = 0; ca = 0; cb = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;
        while (!(hlt_a && hlt_b) && cyc < 300) begin
            @(posedge clk1);
            #1 cyc++;
            if (hlt_a && ca == 0) ca = cyc;
            if (hlt_b && cb == 0) cb = cyc;
        end
        check({tag, " cycles/w32"}, 64'(ca), 64'(exp_cyc));
        check({tag, " cycles/w16"}, 64'(cb), 64'(exp_cyc));
    endtask

    initial begin
        int s0a, s0b;
        rst = 1'b1; dbg_raddr = 5'd0;
        pl_we = 1'b1; pl_addr = 10'd4; pl_data = 32'd7;
        clear_imem();
        repeat (3) @(posedge clk1);
        #1 pl_we = 1'b0;
        check("rst halted", {62'd0, hlt_a, hlt_b}, 64'd0);
        check("rst pc", {44'd0, ia_a, ia_b}, 64'd0);
        check("rst dmem_we", {62'd0, we_a, we_b}, 64'd0);
        chk_reg("rst r1", 1, 32'd0);

        // back-to-back dependency chain, no stalls
        clear_imem();
        imem[0] = ri(ADDI, 1, 0, 5);
        imem[1] = ri(ADDI, 2, 1, 3);
        imem[2] = rr(ADD, 3, 2, 1);
        imem[3] = HLT;
        run("dep", 8);
        chk_reg("dep r1", 1, 32'd5);
        chk_reg("dep r2", 2, 32'd8);
        chk_reg("dep r3", 3, 32'd13);

        // load-use: exactly one bubble
        clear_imem();
        imem[0] = ri(ADDI, 1, 0, 4);
        imem[1] = ri(LW, 2, 1, 0);
        imem[2] = rr(ADD, 3, 2, 2);
        imem[3] = HLT;
        run("ldu", 9);
        chk_reg("ldu r2", 2, 32'd7);
        chk_reg("ldu r3", 3, 32'd14);

        // taken branch squashes two younger instructions
        clear_imem();
        imem[0] = ri(ADDI, 1, 0, 0);
        imem[1] = ri(BEQZ, 0, 1, 2);
        imem[2] = ri(ADDI, 5, 0, 9);
        imem[3] = ri(ADDI, 6, 0, 9);
        imem[4] = ri(ADDI, 7, 0, 1);
        imem[5] = HLT;
        run("br", 10);
        chk_reg("br r5", 5, 32'd0);
        chk_reg("br r6", 6, 32'd0);
        chk_reg("br r7", 7, 32'd1);

        // store and signed compare
        clear_imem();
        imem[0] = ri(ADDI, 1, 0, -1);
        imem[1] = ri(SLTI, 2, 1, 0);
        imem[2] = ri(SW, 1, 0, 3);
        imem[3] = HLT;
        s0a = st_a; s0b = st_b;
        run("sw", 8);
        chk_reg("sw r2", 2, 32'd1);
        check("sw count/w32", 64'(st_a - s0a), 64'd1);
        check("sw count/w16", 64'(st_b - s0b), 64'd1);
        check("sw addr", {44'd0, sa_a, sa_b}, {44'd0, 10'd3, 10'd3});
        check("sw data/w32", 64'(sd_a), 64'hFFFF_FFFF);
        check("sw data/w16", 64'(sd_b), 64'hFFFF);
        check("sw mem/w32", 64'(dm_a[3]), 64'hFFFF_FFFF);
        check("halted we", {62'd0, we_a, we_b}, 64'd0);

        // reset mid-program aborts the pending store
        s0a = st_a; s0b = st_b;
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk1);
        #1 rst = 1'b1;
        @(posedge clk1);
        #1;
        check("abort pc", {44'd0, ia_a, ia_b}, 64'd0);
        repeat (4) @(posedge clk1);
        #1;
        check("abort stores", 64'((st_a - s0a) + (st_b - s0b)), 64'd0);

        // ALU mix, forwarding priority, not-taken branch, MUL wrap at 16 bits
        clear_imem();
        imem[0]  = ri(ADDI, 1, 0, 16'h4000);
        imem[1]  = ri(ADDI, 2, 0, 4);
        imem[2]  = rr(MUL, 3, 1, 2);
        imem[3]  = rr(SUB, 4, 2, 1);
        imem[4]  = rr(AND_, 5, 1, 2);
        imem[5]  = rr(OR_, 6, 1, 2);
        imem[6]  = rr(SLT, 7, 4, 2);
        imem[7]  = ri(BNEQZ, 0, 0, 5);
        imem[8]  = ri(SUBI, 8, 2, 1);
        imem[9]  = ri(ADDI, 9, 0, 1);
        imem[10] = ri(ADDI, 9, 9, 1);
        imem[11] = rr(ADD, 10, 9, 0);
        imem[12] = HLT;
        run("alu", 17);
        chk_reg("alu mul", 3, 32'h0001_0000);
        chk_reg("alu sub", 4, 32'hFFFF_C004);
        chk_reg("alu and", 5, 32'h0);
        chk_reg("alu or", 6, 32'h4004);
        chk_reg("alu slt", 7, 32'd1);
        chk_reg("alu subi", 8, 32'd3);
        chk_reg("alu fwd", 10, 32'd2);

        // halt blocks younger instruction, holds, and reset restarts
        clear_imem();
        imem[0] = HLT;
        imem[1] = ri(ADDI, 4, 0, 1);
        run("hlt", 5);
        chk_reg("hlt r4", 4, 32'd0);
        repeat (5) @(posedge clk1);
        #1;
        check("hlt hold", {62'd0, hlt_a, hlt_b}, 64'd3);
        check("hlt pc", {44'd0, ia_a, ia_b}, {44'd0, 10'd2, 10'd2});
        rst = 1'b1;
        @(posedge clk1);
        #1;
        check("hlt rst halted", {62'd0, hlt_a, hlt_b}, 64'd0);
        check("hlt rst pc", {44'd0, ia_a, ia_b}, 64'd0);
        run("hlt rerun", 5);
        chk_reg("hlt rerun r4", 4, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
